// File: rtl/mx_block_acc.sv
// mx_block_acc
//
// Block accumulator for the MX datapath. Sums each group of block_size
// signed products coming from the int8 multiplier into one wide signed
// result. It also combines the block's two E8M0 shared scales into one
// unbiased exponent, plus a NaN flag. The result goes to the MX-to-float
// normaliser.
//
// Handshake (both sides use strict valid/ready):
//   - An input beat transfers on a rising edge where i_valid && o_ready.
//   - A result transfers on a rising edge where o_valid && i_ready.
//   - Once o_valid is high, o_sum/o_exp/o_nan stay stable until the
//     result transfers.
//   - o_ready = !o_valid || i_ready. It is combinational from i_ready and
//     never depends on i_valid.
//
// Ports:
//   i_clk, i_rst          clock; asynchronous active-high reset
//   i_prd                 signed product (prd_width)
//   i_scale0, i_scale1    E8M0 block scales, sampled on the first beat only
//   i_valid / o_ready     input handshake
//   o_sum                 signed block sum (acc_width)
//   o_exp                 signed combined exponent, scale0 + scale1 - 254
//   o_nan                 either scale was 0xFF
//   o_valid / i_ready     output handshake
//   o_state               debug view of the control state (0 = ACC, 1 = HOLD)
module mx_block_acc #(
    parameter int bit_width  = 8,
    parameter int prd_width  = 2 * bit_width,
    parameter int block_size = 32,
    parameter int acc_width  = prd_width + $clog2(block_size)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [prd_width-1:0]        i_prd,
    input  logic [7:0]                  i_scale0,
    input  logic [7:0]                  i_scale1,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic signed [acc_width-1:0] o_sum,
    output logic [9:0]                  o_exp,
    output logic                        o_nan,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_state
);

    localparam int cnt_width = $clog2(block_size);

    // The control state is fully determined by o_valid and i_ready.
    // HOLD means a finished result is waiting on the consumer, so the
    // input side stalls. ACC with cnt == 0 is the idle condition.
    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                        state;
    logic [cnt_width-1:0]          cnt;
    logic signed [acc_width-1:0]   acc;
    logic [9:0]                    exp_r;
    logic                          nan_r;

    logic                          accept;
    logic                          xfer;
    logic                          first_beat;
    logic                          last_beat;
    logic signed [acc_width-1:0]   prd_ext;

    assign o_ready    = !o_valid || i_ready;
    assign accept     = i_valid && o_ready;
    assign xfer       = o_valid && i_ready;
    assign first_beat = (cnt == '0);
    assign last_beat  = (cnt == cnt_width'(block_size - 1));
    assign prd_ext    = {{(acc_width - prd_width){i_prd[prd_width-1]}}, i_prd};

    assign state   = (o_valid && !i_ready) ? ST_HOLD : ST_ACC;
    assign o_state = state;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt     <= '0;
            acc     <= '0;
            exp_r   <= '0;
            nan_r   <= 1'b0;
            o_sum   <= '0;
            o_exp   <= '0;
            o_nan   <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            // The drain clears o_valid. A last beat accepted in the same
            // cycle overrides this below and keeps o_valid high with new data.
            if (xfer) begin
                o_valid <= 1'b0;
            end
            if (accept) begin
                // block_size is a power of two, so the count wraps naturally.
                cnt <= cnt + cnt_width'(1);
                if (first_beat) begin
                    // Start a fresh block: discard the old sum and latch the scales.
                    acc   <= prd_ext;
                    exp_r <= {2'b00, i_scale0} + {2'b00, i_scale1} - 10'd254;
                    nan_r <= (i_scale0 == 8'hFF) || (i_scale1 == 8'hFF);
                end else begin
                    acc <= acc + prd_ext;
                end
                // block_size >= 2, so a last beat is never also a first beat.
                if (last_beat) begin
                    o_sum   <= acc + prd_ext;
                    o_exp   <= exp_r;
                    o_nan   <= nan_r;
                    o_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mx_block_acc.sv
// Directed testbench for mx_block_acc with the default parameters
// (8-bit operands, 16-bit products, 32-beat blocks, 21-bit sums).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mx_block_acc;

    logic               clk;
    logic               rst;
    logic [15:0]        i_prd;
    logic [7:0]         i_scale0;
    logic [7:0]         i_scale1;
    logic               i_valid;
    logic               o_ready;
    logic signed [20:0] o_sum;
    logic [9:0]         o_exp;
    logic               o_nan;
    logic               o_valid;
    logic               i_ready;
    logic               o_state;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [20:0] exp_q[$];

    mx_block_acc dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_prd    (i_prd),
        .i_scale0 (i_scale0),
        .i_scale1 (i_scale1),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .o_sum    (o_sum),
        .o_exp    (o_exp),
        .o_nan    (o_nan),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_state  (o_state)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one beat and return at the next falling edge. The rising edge in
    // between consumes the beat.
    task automatic drive_beat(input logic [15:0] prd, input logic [7:0] s0, input logic [7:0] s1);
        i_valid  = 1'b1;
        i_prd    = prd;
        i_scale0 = s0;
        i_scale1 = s1;
        @(negedge clk);
    endtask

    // Drive a full block of identical products. When nan_beat >= 0, that beat
    // carries scale0 = 0xFF instead of s0.
    task automatic drive_block(input logic [15:0] prd, input logic [7:0] s0, input logic [7:0] s1,
                               input int nan_beat);
        for (int j = 0; j < 32; j++) begin
            drive_beat(prd, (j == nan_beat) ? 8'hFF : s0, s1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_prd = '0; i_scale0 = '0; i_scale1 = '0; i_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_cnt++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", o_valid); else pass_cnt++;
        check_cnt++; if (o_sum !== 21'd0) $display("FAIL reset_sum: got %0d expected 0", o_sum); else pass_cnt++;
        check_cnt++; if (o_exp !== 10'd0) $display("FAIL reset_exp: got %0d expected 0", o_exp); else pass_cnt++;
        check_cnt++; if (o_nan !== 1'b0) $display("FAIL reset_nan: got %0b expected 0", o_nan); else pass_cnt++;
        check_cnt++; if (o_ready !== 1'b1) $display("FAIL reset_ready: got %0b expected 1", o_ready); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unit_block();
        i_ready = 1'b1;
        for (int j = 0; j < 32; j++) begin
            drive_beat(16'd1, 8'd127, 8'd127);
            if (j == 30) begin
                check_cnt++; if (o_valid !== 1'b0) $display("FAIL unit_early_valid: got %0b expected 0", o_valid); else pass_cnt++;
            end
        end
        i_valid = 1'b0;
        check_cnt++; if (o_valid !== 1'b1) $display("FAIL unit_valid: got %0b expected 1", o_valid); else pass_cnt++;
        check_cnt++; if (o_sum !== 21'sd32) $display("FAIL unit_sum: got %0d expected 32", o_sum); else pass_cnt++;
        check_cnt++; if (o_exp !== 10'd0) $display("FAIL unit_exp: got %0d expected 0", o_exp); else pass_cnt++;
        check_cnt++; if (o_nan !== 1'b0) $display("FAIL unit_nan: got %0b expected 0", o_nan); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (o_valid !== 1'b0) $display("FAIL unit_drain: got %0b expected 0", o_valid); else pass_cnt++;
    endtask

    task automatic test_extremes();
        logic signed [20:0] e_pos;
        logic signed [20:0] e_neg;
        e_pos = 21'sd524288;
        e_neg = -21'sd520192;
        drive_block(16'd16384, 8'd127, 8'd127, -1);
        check_cnt++; if (o_valid !== 1'b1 || o_sum !== e_pos)
            $display("FAIL ext_pos: got valid=%0b sum=%0d expected valid=1 sum=%0d", o_valid, o_sum, e_pos); else pass_cnt++;
        drive_block(16'hC080, 8'd127, 8'd127, -1);
        i_valid = 1'b0;
        check_cnt++; if (o_valid !== 1'b1 || o_sum !== e_neg)
            $display("FAIL ext_neg: got valid=%0b sum=%0d expected valid=1 sum=%0d", o_valid, o_sum, e_neg); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        i_ready = 1'b1;
        for (int j = 0; j < 31; j++) drive_beat(16'd2, 8'd128, 8'd129);
        i_ready = 1'b0;
        drive_beat(16'd2, 8'd128, 8'd129);
        // The result is now waiting. Offer the next block's first beat while stalled.
        i_valid = 1'b1; i_prd = 16'd5; i_scale0 = 8'd130; i_scale1 = 8'd130;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_cnt++; if (o_ready !== 1'b0 || o_state !== 1'b1)
                $display("FAIL bp_ready_c%0d: got ready=%0b state=%0b expected ready=0 state=1", c, o_ready, o_state); else pass_cnt++;
            check_cnt++; if (o_valid !== 1'b1 || o_sum !== 21'sd64 || o_exp !== 10'd3 || o_nan !== 1'b0)
                $display("FAIL bp_hold_c%0d: got v=%0b sum=%0d exp=%0d nan=%0b expected v=1 sum=64 exp=3 nan=0",
                         c, o_valid, o_sum, o_exp, o_nan); else pass_cnt++;
        end
        i_ready = 1'b1;
        #1;
        check_cnt++; if (o_ready !== 1'b1) $display("FAIL bp_release_ready: got %0b expected 1", o_ready); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (o_valid !== 1'b0) $display("FAIL bp_xfer: got %0b expected 0", o_valid); else pass_cnt++;
        // Scales on non-first beats must be ignored, including 0xFF.
        for (int j = 0; j < 31; j++) drive_beat(16'd5, 8'hFF, 8'hFF);
        i_valid = 1'b0;
        check_cnt++; if (o_valid !== 1'b1 || o_sum !== 21'sd160 || o_exp !== 10'd6 || o_nan !== 1'b0)
            $display("FAIL bp_next_block: got v=%0b sum=%0d exp=%0d nan=%0b expected v=1 sum=160 exp=6 nan=0",
                     o_valid, o_sum, o_exp, o_nan); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_scales();
        i_ready = 1'b1;
        drive_block(16'd1, 8'd0, 8'd0, -1);
        check_cnt++; if (o_valid !== 1'b1 || o_exp !== 10'h302 || o_nan !== 1'b0)
            $display("FAIL scale_min: got v=%0b exp=%0d nan=%0b expected v=1 exp=-254 nan=0", o_valid, $signed(o_exp), o_nan); else pass_cnt++;
        drive_block(16'd1, 8'd254, 8'd254, -1);
        check_cnt++; if (o_valid !== 1'b1 || o_exp !== 10'd254 || o_nan !== 1'b0)
            $display("FAIL scale_max: got v=%0b exp=%0d nan=%0b expected v=1 exp=254 nan=0", o_valid, $signed(o_exp), o_nan); else pass_cnt++;
        drive_block(16'd3, 8'd127, 8'd127, 0);
        check_cnt++; if (o_valid !== 1'b1 || o_nan !== 1'b1 || o_exp !== 10'd128 || o_sum !== 21'sd96)
            $display("FAIL scale_nan_first: got v=%0b nan=%0b exp=%0d sum=%0d expected v=1 nan=1 exp=128 sum=96",
                     o_valid, o_nan, $signed(o_exp), o_sum); else pass_cnt++;
        drive_block(16'd1, 8'd127, 8'd127, 5);
        i_valid = 1'b0;
        check_cnt++; if (o_valid !== 1'b1 || o_nan !== 1'b0 || o_exp !== 10'd0)
            $display("FAIL scale_nan_beat5: got v=%0b nan=%0b exp=%0d expected v=1 nan=0 exp=0", o_valid, o_nan, $signed(o_exp)); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] p;
        logic        want_valid;
        logic [20:0] want_sum;
        i_ready = 1'b1;
        exp_q.push_back(21'd32);
        exp_q.push_back(-21'sd32);
        exp_q.push_back(21'd0);
        for (int k = 0; k < 96; k++) begin
            if (k < 32)      p = 16'd1;
            else if (k < 64) p = 16'hFFFF;
            else             p = (k % 2 == 0) ? 16'd1 : 16'hFFFF;
            drive_beat(p, 8'd127, 8'd127);
            // After beat k+1 (beat 1 lands in cycle 1), this sample is cycle k+2.
            want_valid = ((k + 1) % 32 == 0);
            check_cnt++; if (o_valid !== want_valid)
                $display("FAIL b2b_valid_cycle%0d: got %0b expected %0b", k + 2, o_valid, want_valid); else pass_cnt++;
            if (o_valid === 1'b1 && exp_q.size() > 0) begin
                want_sum = exp_q.pop_front();
                check_cnt++; if (o_sum !== want_sum)
                    $display("FAIL b2b_sum_cycle%0d: got %0d expected %0d", k + 2, o_sum, $signed(want_sum)); else pass_cnt++;
            end
        end
        i_valid = 1'b0;
        check_cnt++; if (exp_q.size() != 0) $display("FAIL b2b_missing: got %0d results pending expected 0", exp_q.size()); else pass_cnt++;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        i_ready = 1'b1;
        for (int j = 0; j < 10; j++) drive_beat(16'd7, 8'd127, 8'd127);
        i_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_cnt++; if (o_valid !== 1'b0 || o_sum !== 21'd0)
            $display("FAIL mid_rst_state: got v=%0b sum=%0d expected v=0 sum=0", o_valid, o_sum); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 32; j++) begin
            drive_beat(16'd2, 8'd127, 8'd127);
            if (j < 31) begin
                check_cnt++; if (o_valid !== 1'b0)
                    $display("FAIL mid_rst_spurious_beat%0d: got %0b expected 0", j + 1, o_valid); else pass_cnt++;
            end
        end
        i_valid = 1'b0;
        check_cnt++; if (o_valid !== 1'b1 || o_sum !== 21'sd64)
            $display("FAIL mid_rst_result: got v=%0b sum=%0d expected v=1 sum=64", o_valid, o_sum); else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_unit_block();
        test_extremes();
        test_backpressure();
        test_scales();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
